// File: rtl/prime_checker.sv
// Sequential primality tester: trial division by repeated subtraction, d*d tracked incrementally.
// Optional PRIME_COUNT_EN adds a saturating 16-bit count of prime results on count_o.
module prime_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             valid_o,
`ifdef PRIME_COUNT_EN
  output logic [15:0]      count_o,
`endif
  output logic             prime_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TEST   = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   n, d, r;
  logic [2*WIDTH-1:0] sq;
  logic [2*WIDTH-1:0] n_ext;
  logic [2*WIDTH-1:0] sq_step;
`ifdef PRIME_COUNT_EN
  logic [15:0]        count;
  assign count_o = count;
`endif

  assign n_ext   = {{WIDTH{1'b0}}, n};
  // (d+1)^2 = d^2 + 2d + 1
  assign sq_step = {{(WIDTH-1){1'b0}}, d, 1'b1};

  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n       <= '0;
      d       <= '0;
      r       <= '0;
      sq      <= '0;
      prime_o <= 1'b0;
`ifdef PRIME_COUNT_EN
      count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (en_i) begin
          n       <= data_i;
          r       <= data_i;
          d       <= WIDTH'(2);
          sq      <= (2*WIDTH)'(4);
          prime_o <= 1'b0;
          state   <= TEST;
        end
        TEST: begin
          if (n < WIDTH'(2)) begin
            prime_o <= 1'b0;
            state   <= DONE;
          end else if (sq > n_ext) begin
            prime_o <= 1'b1;
            state   <= DONE;
`ifdef PRIME_COUNT_EN
            if (count != 16'hFFFF) count <= count + 16'd1;
`endif
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (r == '0) begin
            prime_o <= 1'b0;
            state   <= DONE;
          end else if (r < d) begin
            d     <= d + WIDTH'(1);
            sq    <= sq + sq_step;
            r     <= n;
            state <= TEST;
          end else begin
            r <= r - d;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_checker.sv
// Directed bench for prime_checker: reset, latency, full 8-bit sweep, busy/back-to-back handling.
module tb_prime_checker;

  logic       clk, rst_n, en_i;
  logic [7:0] data_i;
  logic       busy_o, valid_o, prime_o;
`ifdef PRIME_COUNT_EN
  logic [15:0] count_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic sweep_prime [256];

  prime_checker #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .data_i (data_i),
    .busy_o (busy_o),
    .valid_o(valid_o),
`ifdef PRIME_COUNT_EN
    .count_o(count_o),
`endif
    .prime_o(prime_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_prime(input int v);
    if (v < 2) return 1'b0;
    for (int k = 2; k < v; k++) if (v % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Edges from capture to the DONE cycle: TEST->DIVIDE, one edge per subtraction, exit edge.
  function automatic int exp_lat(input int v);
    int l;
    if (v < 2) return 2;
    l = 1;
    for (int k = 2; k * k <= v; k++) begin
      l += 1 + v / k;
      if (v % k == 0) return l + 1;
      l += 1;
    end
    return l + 1;
  endfunction

  // Issues one request and measures it; lat=-1 means valid_o never arrived.
  task automatic do_req(input logic [7:0] v, output int lat, output logic pr,
                        output logic busy_ok, output logic pulse_ok);
    lat = -1; pr = 1'b0; busy_ok = 1'b1; pulse_ok = 1'b0;
    @(negedge clk);
    en_i = 1'b1; data_i = v;
    @(posedge clk);
    #1 en_i = 1'b0; data_i = 8'($urandom);
    for (int e = 1; e <= 4000; e++) begin
      @(negedge clk);
      if (valid_o) begin lat = e; pr = prime_o; break; end
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk);
    end
    if (lat > 0) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk);
      pulse_ok = !valid_o && !busy_o && (prime_o === pr);
    end
  endtask

  task automatic test_reset;
    int lat; logic pr, bok, pok;
    rst_n = 1'b0; en_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, valid_o, prime_o} !== 3'b000) begin
      failures++; $display("FAIL reset_state: busy/valid/prime=%b required 000", {busy_o, valid_o, prime_o});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy_o, valid_o);
    end
    // prime_o held high from a prior result must clear asynchronously
    do_req(8'd5, lat, pr, bok, pok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (prime_o !== 1'b0) begin
      failures++; $display("FAIL reset_prime_async: prime=%b required 0", prime_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); en_i = 1'b1; data_i = 8'd251;
    @(posedge clk); #1 en_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL mid_busy_before_reset: busy=%b required 1", busy_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, valid_o, prime_o} !== 3'b000) begin
      failures++; $display("FAIL mid_reset_async: busy/valid/prime=%b required 000", {busy_o, valid_o, prime_o});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
        failures++; $display("FAIL mid_reset_idle: busy=%b valid=%b required 0 0", busy_o, valid_o);
      end
    end
  endtask

  task automatic test_small;
    int lat; logic pr, bok, pok;
    logic [3:0] exp_p;
    exp_p = 4'b1100;
    for (int v = 0; v < 4; v++) begin
      do_req(8'(v), lat, pr, bok, pok);
      checks++;
      if (lat != 2 || pr !== exp_p[v] || !pok) begin
        failures++;
        $display("FAIL small_%0d: lat=%0d prime=%b pulse_ok=%b required lat=2 prime=%b pulse_ok=1",
                 v, lat, pr, pok, exp_p[v]);
      end
    end
  endtask

  task automatic test_latency;
    int lat; logic pr, bok, pok;
    do_req(8'd4, lat, pr, bok, pok);
    checks++;
    if (lat != 5 || pr !== 1'b0 || !pok || !bok) begin
      failures++; $display("FAIL latency_4: lat=%0d prime=%b pulse_ok=%b busy_ok=%b required 5 0 1 1", lat, pr, pok, bok);
    end
    do_req(8'd5, lat, pr, bok, pok);
    checks++;
    if (lat != 6 || pr !== 1'b1 || !pok || !bok) begin
      failures++; $display("FAIL latency_5: lat=%0d prime=%b pulse_ok=%b busy_ok=%b required 6 1 1 1", lat, pr, pok, bok);
    end
  endtask

  task automatic test_sweep;
    int lat; logic pr, bok, pok;
    int cp_val [7];
    logic cp_exp [7];
    cp_val = '{9, 25, 49, 97, 169, 251, 255};
    cp_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 256; v++) begin
      do_req(8'(v), lat, pr, bok, pok);
      sweep_prime[v] = pr;
      checks++;
      if (pr !== ref_prime(v) || lat != exp_lat(v) || !bok || !pok) begin
        failures++;
        $display("FAIL sweep_%0d: prime=%b lat=%0d busy_ok=%b pulse_ok=%b required prime=%b lat=%0d 1 1",
                 v, pr, lat, bok, pok, ref_prime(v), exp_lat(v));
      end
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (sweep_prime[cp_val[i]] !== cp_exp[i]) begin
        failures++; $display("FAIL checkpoint_%0d: prime=%b required %b", cp_val[i], sweep_prime[cp_val[i]], cp_exp[i]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk); en_i = 1'b1; data_i = 8'd97;
    @(posedge clk); #1 en_i = 1'b0;
    repeat (3) @(negedge clk);
    en_i = 1'b1; data_i = 8'd4;
    @(negedge clk); en_i = 1'b0;
    lat = -1;
    for (int e = 0; e < 2000; e++) begin
      if (valid_o) begin lat = e; break; end
      @(negedge clk);
    end
    checks++;
    if (lat < 0 || prime_o !== 1'b1) begin
      failures++; $display("FAIL busy_ignore_result: seen=%0d prime=%b required valid seen, prime=1", lat, prime_o);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
        failures++; $display("FAIL busy_ignore_no_queue: busy=%b required 0", busy_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic first_ok;
    @(negedge clk); en_i = 1'b1; data_i = 8'd97;
    @(posedge clk); #1 data_i = 8'd4;
    first_ok = 1'b0;
    for (int e = 0; e < 2000; e++) begin
      @(negedge clk);
      if (valid_o) begin first_ok = (prime_o === 1'b1); break; end
    end
    checks++;
    if (!first_ok) begin
      failures++; $display("FAIL b2b_first: prime=%b valid=%b required prime=1 after valid", prime_o, valid_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL b2b_idle_gap: busy=%b required 0", busy_o);
    end
    @(negedge clk);
    en_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL b2b_capture: busy=%b required 1", busy_o);
    end
    lat = -1;
    for (int e = 1; e <= 50; e++) begin
      if (valid_o) begin lat = e; break; end
      @(negedge clk);
    end
    checks++;
    if (lat != 5 || prime_o !== 1'b0) begin
      failures++; $display("FAIL b2b_second: lat=%0d prime=%b required 5 0", lat, prime_o);
    end
    @(negedge clk);
  endtask

`ifdef PRIME_COUNT_EN
  task automatic test_count;
    int lat; logic pr, bok, pok;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (count_o !== 16'd0) begin
      failures++; $display("FAIL count_reset: count=%0d required 0", count_o);
    end
    for (int v = 0; v < 256; v++) do_req(8'(v), lat, pr, bok, pok);
    checks++;
    if (count_o !== 16'd54) begin
      failures++; $display("FAIL count_sweep: count=%0d required 54", count_o);
    end
    @(negedge clk);
    force dut.count = 16'hFFFF;
    #1 release dut.count;
    do_req(8'd7, lat, pr, bok, pok);
    checks++;
    if (count_o !== 16'hFFFF || pr !== 1'b1) begin
      failures++; $display("FAIL count_saturate: count=%h prime=%b required ffff 1", count_o, pr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_small();
    test_latency();
    test_sweep();
    test_busy_ignore();
    test_back_to_back();
`ifdef PRIME_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
